lag_energy_acc: RTL and testbench

- Upstream feeder for the inverse-square-root stage (Inv_sqrtPipe) in the G.729 open-loop pitch search (Lag_max energy normalisation).
- Reads LEN 16-bit signal samples from shared scratch memory and accumulates a saturating sum of squares (L_mac semantics).
- Writes the 32-bit energy to the inverse-square-root input address, pulses the start of that stage, waits for its done, then reports done.

---
 rtl/lag_energy_acc.sv | 198 +++++++++++++++++++
 tb/tb_lag_energy_acc.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/lag_energy_acc.sv
// lag_energy_acc: reads a run of 16-bit samples from scratch memory, forms the
// saturating sum of squares with L_mult/L_add semantics, stores the energy at
// the inverse-square-root input word, kicks that stage and waits for it to
// finish before reporting done.
module lag_energy_acc #(
    parameter int ADDR_W = 11,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] sigAddr,
    input  logic [LEN_W-1:0]  len,
    input  logic [ADDR_W-1:0] L_xAddr,
    output logic [ADDR_W-1:0] readAddr,
    input  logic [31:0]       memIn,
    output logic [ADDR_W-1:0] writeAddr,
    output logic [31:0]       memOut,
    output logic              memWriteEn,
    output logic              sqrtStart,
    input  logic              sqrtDone,
    output logic [31:0]       energy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_DRAIN = 3'd2,
        S_WRITE = 3'd3,
        S_KICK  = 3'd4,
        S_WAIT  = 3'd5,
        S_FIN   = 3'd6
    } state_t;

    // L_mult(x,x): doubled square, with the single overflow case 0x8000 clamped.
    function automatic logic [31:0] l_mult_sq(input logic [15:0] x);
        logic signed [31:0] xs;
        logic signed [31:0] prod;
        xs   = {{16{x[15]}}, x};
        prod = xs * xs;
        if (x == 16'h8000) begin
            return 32'h7FFF_FFFF;
        end else begin
            return {prod[30:0], 1'b0};
        end
    endfunction

    // L_add for two non-negative operands: only positive saturation can occur.
    function automatic logic [31:0] l_add_pos(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s > 33'h0_7FFF_FFFF) begin
            return 32'h7FFF_FFFF;
        end else begin
            return s[31:0];
        end
    endfunction

    state_t              state_r, next_state_s;
    logic [ADDR_W-1:0]   base_r, base_s;
    logic [LEN_W-1:0]    len_r, len_s;
    logic [ADDR_W-1:0]   dst_r, dst_s;
    logic [LEN_W-1:0]    cnt_r, cnt_s;
    logic [31:0]         acc_r, acc_s;
    logic [31:0]         acc_add_s;
    logic [ADDR_W-1:0]   read_addr_s, write_addr_s;
    logic [31:0]         mem_out_s, energy_s;
    logic                mem_we_s, sqrt_start_s, done_s;
    logic                unused_hi_s;

    // Upper half of each memory word carries no sample data.
    assign unused_hi_s = ^memIn[31:16];

    // Accumulator plus the square of the sample currently on the read bus.
    assign acc_add_s = l_add_pos(acc_r, l_mult_sq(memIn[15:0]));

    // Next-state and next-output decode; every register holds by default.
    always_comb begin
        next_state_s = state_r;
        base_s       = base_r;
        len_s        = len_r;
        dst_s        = dst_r;
        cnt_s        = cnt_r;
        acc_s        = acc_r;
        read_addr_s  = readAddr;
        write_addr_s = writeAddr;
        mem_out_s    = memOut;
        energy_s     = energy;
        mem_we_s     = 1'b0;
        sqrt_start_s = 1'b0;
        done_s       = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    base_s = sigAddr;
                    len_s  = len;
                    dst_s  = L_xAddr;
                    acc_s  = 32'h0000_0000;
                    if (len == {LEN_W{1'b0}}) begin
                        // Empty run: store a zero energy straight away.
                        cnt_s        = {LEN_W{1'b0}};
                        next_state_s = S_WRITE;
                        mem_we_s     = 1'b1;
                        write_addr_s = L_xAddr;
                        mem_out_s    = 32'h0000_0000;
                        energy_s     = 32'h0000_0000;
                    end else begin
                        cnt_s        = {{(LEN_W-1){1'b0}}, 1'b1};
                        next_state_s = S_FETCH;
                        read_addr_s  = sigAddr;
                    end
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_FETCH: begin
                // Data for the address issued last cycle arrives from the
                // second FETCH cycle onward.
                if (cnt_r > {{(LEN_W-1){1'b0}}, 1'b1}) begin
                    acc_s = acc_add_s;
                end else begin
                    acc_s = acc_r;
                end
                if (cnt_r == len_r) begin
                    next_state_s = S_DRAIN;
                end else begin
                    read_addr_s = base_r + ADDR_W'(cnt_r);
                    cnt_s       = cnt_r + {{(LEN_W-1){1'b0}}, 1'b1};
                end
            end
            S_DRAIN: begin
                acc_s        = acc_add_s;
                next_state_s = S_WRITE;
                mem_we_s     = 1'b1;
                write_addr_s = dst_r;
                mem_out_s    = acc_add_s;
                energy_s     = acc_add_s;
            end
            S_WRITE: begin
                next_state_s = S_KICK;
                sqrt_start_s = 1'b1;
            end
            S_KICK: begin
                // Any sqrtDone during the kick cycle is stale and ignored.
                next_state_s = S_WAIT;
            end
            S_WAIT: begin
                if (sqrtDone) begin
                    next_state_s = S_FIN;
                    done_s       = 1'b1;
                end else begin
                    next_state_s = S_WAIT;
                end
            end
            S_FIN: begin
                next_state_s = S_IDLE;
            end
            default: begin
                next_state_s = S_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs; reset aborts any run at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= S_IDLE;
            base_r     <= {ADDR_W{1'b0}};
            len_r      <= {LEN_W{1'b0}};
            dst_r      <= {ADDR_W{1'b0}};
            cnt_r      <= {LEN_W{1'b0}};
            acc_r      <= 32'h0000_0000;
            readAddr   <= {ADDR_W{1'b0}};
            writeAddr  <= {ADDR_W{1'b0}};
            memOut     <= 32'h0000_0000;
            energy     <= 32'h0000_0000;
            memWriteEn <= 1'b0;
            sqrtStart  <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            base_r     <= base_s;
            len_r      <= len_s;
            dst_r      <= dst_s;
            cnt_r      <= cnt_s;
            acc_r      <= acc_s;
            readAddr   <= read_addr_s;
            writeAddr  <= write_addr_s;
            memOut     <= mem_out_s;
            energy     <= energy_s;
            memWriteEn <= mem_we_s;
            sqrtStart  <= sqrt_start_s;
            done       <= done_s;
        end
    end

endmodule

// File: tb/tb_lag_energy_acc.sv
// Directed bench for lag_energy_acc with a synchronous-read memory model.
module tb_lag_energy_acc;

    logic        clk;
    logic        reset;
    logic        start;
    logic [10:0] sigAddr;
    logic [7:0]  len;
    logic [10:0] L_xAddr;
    logic [10:0] readAddr;
    logic [31:0] memIn;
    logic [10:0] writeAddr;
    logic [31:0] memOut;
    logic        memWriteEn;
    logic        sqrtStart;
    logic        sqrtDone;
    logic [31:0] energy;
    logic        done;

    logic [31:0] mem [0:2047];
    int          writeCount;
    int          doneCount;
    logic [31:0] lastWData;
    int          errors;
    int          checks;
    logic [31:0] wval;
    int          wc0;
    int          dc0;

    lag_energy_acc #(.ADDR_W(11), .LEN_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .sigAddr(sigAddr), .len(len),
        .L_xAddr(L_xAddr), .readAddr(readAddr), .memIn(memIn), .writeAddr(writeAddr),
        .memOut(memOut), .memWriteEn(memWriteEn), .sqrtStart(sqrtStart),
        .sqrtDone(sqrtDone), .energy(energy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memory and write/done monitors.
    always @(posedge clk) begin
        memIn <= mem[readAddr];
        if (memWriteEn) begin
            writeCount <= writeCount + 1;
            lastWData  <= memOut;
        end
        if (done) doneCount <= doneCount + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load(input int addr, input int n, input logic [15:0] v);
        for (int i = 0; i < n; i++) mem[(addr + i) % 2048] = {16'hABCD, v};
    endtask

    // Full operation: start, wait for the write, wait for the kick, answer done.
    task automatic do_op(input logic [10:0] a, input logic [7:0] n, input logic [10:0] d,
                         input string tag, output logic [31:0] wv);
        bit ok;
        @(negedge clk);
        sigAddr = a; len = n; L_xAddr = d; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (memWriteEn) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        check({tag, "_write_seen"}, {31'd0, ok}, 32'd1);
        wv = memOut;
        check({tag, "_waddr"}, {21'd0, writeAddr}, {21'd0, d});
        ok = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (sqrtStart) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        check({tag, "_kick_seen"}, {31'd0, ok}, 32'd1);
        @(negedge clk);
        sqrtDone = 1'b1;
        @(negedge clk);
        sqrtDone = 1'b0;
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_energy"}, energy, wv);
    endtask

    initial begin
        errors = 0; checks = 0; writeCount = 0; doneCount = 0; lastWData = 32'd0;
        reset = 1'b0; start = 1'b0; sigAddr = 11'd0; len = 8'd0; L_xAddr = 11'd0;
        sqrtDone = 1'b0;
        for (int i = 0; i < 2048; i++) mem[i] = 32'h0000_0000;
        mem[100] = 32'hFFFF_0001; mem[101] = 32'h1234_0002;
        mem[102] = 32'h0000_0003; mem[103] = 32'h5555_0004;
        repeat (3) @(negedge clk);
        check("rst_readAddr", {21'd0, readAddr}, 32'd0);
        check("rst_outs", {29'd0, memWriteEn, sqrtStart, done}, 32'd0);
        check("rst_energy", energy, 32'd0);
        reset = 1'b1;

        // Test 1: len=4, samples 1..4, cycle-accurate latency checks.
        @(negedge clk);
        sigAddr = 11'd100; len = 8'd4; L_xAddr = 11'd512; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t1_addr0", {21'd0, readAddr}, 32'd100);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            check("t1_addr", {21'd0, readAddr}, 32'd100 + i);
        end
        @(negedge clk);
        check("t1_drain_nowe", {31'd0, memWriteEn}, 32'd0);
        @(negedge clk);
        check("t1_we", {31'd0, memWriteEn}, 32'd1);
        check("t1_waddr", {21'd0, writeAddr}, 32'd512);
        check("t1_data", memOut, 32'h0000_003C);
        @(negedge clk);
        check("t1_kick", {30'd0, sqrtStart, memWriteEn}, 32'd2);
        sqrtDone = 1'b1;   // coincides with the kick cycle: must be ignored
        @(negedge clk);
        sqrtDone = 1'b0;
        check("t1_kick_once", {31'd0, sqrtStart}, 32'd0);
        @(negedge clk);
        check("t1_no_early_done", {31'd0, done}, 32'd0);
        sqrtDone = 1'b1;
        @(negedge clk);
        sqrtDone = 1'b0;
        check("t1_done", {31'd0, done}, 32'd1);
        @(negedge clk);
        check("t1_done_once", {31'd0, done}, 32'd0);
        check("t1_energy", energy, 32'h0000_003C);
        check("t1_writes", writeCount, 32'd1);

        // Single-sample boundary values.
        load(200, 1, 16'h8000);
        do_op(11'd200, 8'd1, 11'd600, "t2_min", wval);
        check("t2_min_val", wval, 32'h7FFF_FFFF);
        load(201, 1, 16'hFFFD);
        do_op(11'd201, 8'd1, 11'd601, "t3_neg3", wval);
        check("t3_neg3_val", wval, 32'h0000_0012);

        // Saturation: 40 x 0x7FFF.
        load(1000, 40, 16'h7FFF);
        do_op(11'd1000, 8'd40, 11'd700, "t4_sat", wval);
        check("t4_sat_val", wval, 32'h7FFF_FFFF);

        // len=0: write on the first cycle.
        @(negedge clk);
        sigAddr = 11'd5; len = 8'd0; L_xAddr = 11'd77; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t5_len0_we", {31'd0, memWriteEn}, 32'd1);
        check("t5_len0_data", memOut, 32'd0);
        check("t5_len0_waddr", {21'd0, writeAddr}, 32'd77);
        @(negedge clk);
        check("t5_len0_kick", {31'd0, sqrtStart}, 32'd1);
        @(negedge clk);
        sqrtDone = 1'b1;
        @(negedge clk);
        sqrtDone = 1'b0;
        check("t5_len0_done", {31'd0, done}, 32'd1);
        check("t5_len0_energy", energy, 32'd0);

        // Address wrap: 2046,2047,0,1 each holding 1.
        load(2046, 4, 16'h0001);
        do_op(11'd2046, 8'd4, 11'd50, "t6_wrap", wval);
        check("t6_wrap_val", wval, 32'h0000_0008);

        // sqrtDone stuck high in IDLE has no effect.
        @(negedge clk);
        dc0 = doneCount;
        sqrtDone = 1'b1;
        repeat (5) @(negedge clk);
        sqrtDone = 1'b0;
        check("t7_idle_sqrtdone", doneCount - dc0, 32'd0);

        // Start re-pulsed during FETCH and WAIT.
        load(300, 8, 16'd10);
        wc0 = writeCount; dc0 = doneCount;
        @(negedge clk);
        sigAddr = 11'd300; len = 8'd8; L_xAddr = 11'd400; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (sqrtStart) break;
            @(negedge clk);
        end
        check("t8_kick", {31'd0, sqrtStart}, 32'd1);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        sqrtDone = 1'b1;
        @(negedge clk);
        sqrtDone = 1'b0;
        check("t8_done", {31'd0, done}, 32'd1);
        repeat (15) @(negedge clk);
        check("t8_writes", writeCount - wc0, 32'd1);
        check("t8_dones", doneCount - dc0, 32'd1);
        check("t8_val", lastWData, 32'h0000_0640);

        // Reset mid-FETCH aborts; then len=2 of 5,5.
        wc0 = writeCount;
        @(negedge clk);
        sigAddr = 11'd300; len = 8'd8; L_xAddr = 11'd401; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("t9_rst_addr", {10'd0, writeAddr, readAddr}, 32'd0);
        check("t9_rst_outs", {29'd0, memWriteEn, sqrtStart, done}, 32'd0);
        check("t9_rst_energy", energy, 32'd0);
        check("t9_rst_memout", memOut, 32'd0);
        repeat (12) @(negedge clk);
        check("t9_no_write", writeCount - wc0, 32'd0);
        reset = 1'b1;
        load(900, 2, 16'd5);
        do_op(11'd900, 8'd2, 11'd402, "t10_after_rst", wval);
        check("t10_val", wval, 32'h0000_0064);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
